// File: rtl/dial_pkg.sv
// Shared constants, record layout and controller state type for the dial sequencer.
package dial_pkg;

    localparam int unsigned DIAL_SIZE = 100;
    localparam int unsigned START_POS = 50;
    localparam int unsigned DIR_BIT   = 10;
    localparam int unsigned AMT_MSB   = 9;

    // Record field widths.
    localparam int unsigned AMT_W  = AMT_MSB + 1;
    localparam int unsigned REC_W  = DIR_BIT + 1;
    localparam int unsigned POS_W  = 7;
    localparam int unsigned PASS_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_EXEC,
        S_DONE
    } state_t;

endpackage

// File: rtl/dial_op_sequencer_if.sv
// Op memory read port: the sequencer drives enable/address, the memory returns a record.
interface dial_op_sequencer_if #(
    parameter int unsigned ADDR_W = 13
);
    import dial_pkg::*;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [REC_W-1:0]  mem_rdata;

    modport master (output mem_en, output mem_addr, input mem_rdata);
    modport slave  (input mem_en, input mem_addr, output mem_rdata);

endinterface

// File: rtl/dial_step.sv
// Combinational single-record dial rotation: new position, zero-click count, landing flag.
module dial_step
    import dial_pkg::*;
(
    input  logic [POS_W-1:0]  pos,
    input  logic              dir,
    input  logic [AMT_W-1:0]  amount,
    output logic [POS_W-1:0]  new_pos,
    output logic [PASS_W-1:0] pass_inc,
    output logic              hit
);

    logic [PASS_W-1:0] q;
    logic [POS_W-1:0]  r;
    logic [POS_W:0]    sum;
    logic              wrap;

    // Full turns each pass zero once; the remainder passes zero at most once more.
    always_comb begin
        q   = PASS_W'(amount / AMT_W'(DIAL_SIZE));
        r   = POS_W'(amount % AMT_W'(DIAL_SIZE));
        sum = {1'b0, pos} + {1'b0, r};
        if (dir) begin
            wrap    = (sum >= (POS_W+1)'(DIAL_SIZE));
            new_pos = wrap ? POS_W'(sum - (POS_W+1)'(DIAL_SIZE)) : sum[POS_W-1:0];
        end else begin
            wrap    = (pos != '0) && (r >= pos);
            new_pos = (pos >= r) ? (pos - r)
                                 : POS_W'({1'b0, pos} + (POS_W+1)'(DIAL_SIZE) - {1'b0, r});
        end
        pass_inc = q + PASS_W'(wrap);
        hit      = (new_pos == '0);
    end

endmodule

// File: rtl/dial_op_sequencer.sv
// Walks the op memory one record at a time, applying each to the dial and
// accumulating landings on zero and all zero clicks.
module dial_op_sequencer
    import dial_pkg::*;
#(
    parameter int unsigned N_MAX  = 4186,
    parameter int unsigned ADDR_W = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  op_count,
    input  logic               hold,
    dial_op_sequencer_if.master mem,
    output logic               busy,
    output logic               finished,
    output logic [POS_W-1:0]   dial_pos,
    output logic [31:0]        zero_hits,
    output logic [31:0]        zero_passes
);

    if ((64'd1 << ADDR_W) < 64'(N_MAX)) begin : g_addr_check
        $error("ADDR_W too narrow for N_MAX records");
    end

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] count_r;
    logic              dir_r;
    logic [AMT_W-1:0]  amt_r;

    logic [POS_W-1:0]  step_pos;
    logic [PASS_W-1:0] step_inc;
    logic              step_hit;

    dial_step u_step (
        .pos      (dial_pos),
        .dir      (dir_r),
        .amount   (amt_r),
        .new_pos  (step_pos),
        .pass_inc (step_inc),
        .hit      (step_hit)
    );

    // Read enable follows the state directly so a hold suppresses the fetch in the same cycle.
    always_comb begin
        mem.mem_en   = (state == S_ISSUE) && !hold;
        mem.mem_addr = index;
    end

    // Run controller and all result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            index       <= '0;
            count_r     <= '0;
            dir_r       <= 1'b0;
            amt_r       <= '0;
            busy        <= 1'b0;
            finished    <= 1'b0;
            dial_pos    <= POS_W'(START_POS);
            zero_hits   <= '0;
            zero_passes <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        zero_hits   <= '0;
                        zero_passes <= '0;
                        index       <= '0;
                        finished    <= 1'b0;
                        dial_pos    <= POS_W'(START_POS);
                        count_r     <= op_count;
                        busy        <= 1'b1;
                        state       <= (op_count == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!hold) state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    dir_r <= mem.mem_rdata[DIR_BIT];
                    amt_r <= mem.mem_rdata[AMT_MSB:0];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    dial_pos    <= step_pos;
                    zero_hits   <= zero_hits + 32'(step_hit);
                    zero_passes <= zero_passes + 32'(step_inc);
                    if ((index + ADDR_W'(1)) == count_r) begin
                        state <= S_DONE;
                    end else begin
                        index <= index + ADDR_W'(1);
                        state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    finished <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
